// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the address-phase bundle held per master.
package ahb_pkg;

  localparam int HADDR_W = 32;
  localparam int HSIZE_W = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef struct packed {
    logic [HADDR_W-1:0] addr;
    logic [HSIZE_W-1:0] size;
    logic               write;
  } ahb_addr_t;

endpackage

// File: rtl/ahb_rr_arb_rr_pick.sv
// Rotating-priority picker: first set request at or above i_ptr, wrapping to 0.
// Purely combinational; o_gnt is one-hot or zero.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  logic [PW-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    o_gnt = '0;
    w_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = PW'((int'(i_ptr) + k) % N);
      if (i_req[w_idx]) begin
        o_gnt        = '0;
        o_gnt[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arb.sv
// Round-robin arbiter sharing one AHB-Lite slave among NUM_MASTERS masters.
// Losing requests park in per-master hold registers; a stalled address phase is locked.
module ahb_rr_arb
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int DWIDTH      = 32
) (
  input  logic                                   hclk,
  input  logic                                   hresetn,
  input  logic [NUM_MASTERS-1:0][1:0]            htrans_m,
  input  logic [NUM_MASTERS-1:0][HADDR_W-1:0]    haddr_m,
  input  logic [NUM_MASTERS-1:0][HSIZE_W-1:0]    hsize_m,
  input  logic [NUM_MASTERS-1:0]                 hwrite_m,
  input  logic [NUM_MASTERS-1:0][DWIDTH-1:0]     hwdata_m,
  output logic [NUM_MASTERS-1:0][DWIDTH-1:0]     hrdata_m,
  output logic [NUM_MASTERS-1:0]                 hready_m,
  output logic [NUM_MASTERS-1:0]                 hresp_m,
  output logic                                   hsel_s,
  output logic [HADDR_W-1:0]                     haddr_s,
  output logic [HSIZE_W-1:0]                     hsize_s,
  output logic                                   hwrite_s,
  output logic [DWIDTH-1:0]                      hwdata_s,
  input  logic [DWIDTH-1:0]                      hrdata_s,
  input  logic                                   hready_s,
  input  logic                                   hresp_s,
  output logic [NUM_MASTERS-1:0]                 grant_o
);

  localparam int PW = $clog2(NUM_MASTERS);

  ahb_addr_t               r_hold [NUM_MASTERS];
  logic [NUM_MASTERS-1:0]  r_hold_vld;
  logic                    r_lock_vld;
  logic [PW-1:0]           r_lock_idx;
  logic                    r_dp_vld;
  logic [PW-1:0]           r_dp_own;
  logic [PW-1:0]           r_rr_ptr;

  ahb_addr_t               w_live [NUM_MASTERS];
  ahb_addr_t               w_win_addr;
  logic [NUM_MASTERS-1:0]  w_live_req;
  logic [NUM_MASTERS-1:0]  w_cand;
  logic [NUM_MASTERS-1:0]  w_pick;
  logic [PW-1:0]           w_pidx;
  logic [PW-1:0]           w_win;
  logic                    w_any;
  logic                    w_acc;
  logic                    w_unused_htrans;

  // SEQ and NONSEQ are treated alike, so only bit 1 of htrans matters.
  always_comb begin
    w_unused_htrans = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_unused_htrans = w_unused_htrans ^ htrans_m[i][0];
      w_live[i]       = '{addr: haddr_m[i], size: hsize_m[i], write: hwrite_m[i]};
      if (r_hold_vld[i])
        hready_m[i] = 1'b0;
      else if (r_dp_vld && (r_dp_own == PW'(i)))
        hready_m[i] = hready_s;
      else
        hready_m[i] = 1'b1;
      w_live_req[i] = hresetn && htrans_m[i][1] && hready_m[i];
    end
  end

  assign w_cand = r_hold_vld | w_live_req;

  rr_pick #(.N(NUM_MASTERS), .PW(PW)) u_pick (
    .i_req (w_cand),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick)
  );

  // A presented-but-stalled winner keeps the slot regardless of the picker.
  always_comb begin
    w_pidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (w_pick[i]) w_pidx = PW'(i);
    w_win      = r_lock_vld ? r_lock_idx : w_pidx;
    w_any      = r_lock_vld || (|w_cand);
    w_win_addr = r_hold_vld[w_win] ? r_hold[w_win] : w_live[w_win];
    w_acc      = w_any && hready_s;

    hsel_s   = w_any;
    haddr_s  = w_any ? w_win_addr.addr  : '0;
    hsize_s  = w_any ? w_win_addr.size  : '0;
    hwrite_s = w_any ? w_win_addr.write : 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++)
      grant_o[i] = w_any && (w_win == PW'(i));
  end

  always_comb begin
    hwdata_s = r_dp_vld ? hwdata_m[r_dp_own] : '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_dp_vld && (r_dp_own == PW'(i))) begin
        hrdata_m[i] = hrdata_s;
        hresp_m[i]  = hresp_s;
      end else begin
        hrdata_m[i] = '0;
        hresp_m[i]  = HRESP_OKAY;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_hold_vld <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) r_hold[i] <= '0;
      r_lock_vld <= 1'b0;
      r_lock_idx <= '0;
      r_dp_vld   <= 1'b0;
      r_dp_own   <= '0;
      r_rr_ptr   <= '0;
    end else begin
      // Any live request not accepted this cycle was already seen by its master as taken.
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (w_acc && (w_win == PW'(i))) begin
          r_hold_vld[i] <= 1'b0;
        end else if (w_live_req[i]) begin
          r_hold_vld[i] <= 1'b1;
          r_hold[i]     <= w_live[i];
        end
      end

      if (w_any && !hready_s) begin
        r_lock_vld <= 1'b1;
        r_lock_idx <= w_win;
      end else begin
        r_lock_vld <= 1'b0;
      end

      if (w_acc) begin
        r_dp_vld <= 1'b1;
        r_dp_own <= w_win;
        r_rr_ptr <= (w_win == PW'(NUM_MASTERS - 1)) ? '0 : w_win + 1'b1;
      end else if (hready_s) begin
        r_dp_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_rr_arb.sv
// Bench for ahb_rr_arb: simple AHB master models, a wait-state slave and an ordered scoreboard.
module tb_ahb_rr_arb;
  import ahb_pkg::*;

  localparam int NM = 4;
  localparam int DW = 32;

  logic                      hclk = 1'b0;
  logic                      hresetn = 1'b0;
  logic [NM-1:0][1:0]        htrans_m = '0;
  logic [NM-1:0][31:0]       haddr_m = '0;
  logic [NM-1:0][3:0]        hsize_m = '0;
  logic [NM-1:0]             hwrite_m = '0;
  logic [NM-1:0][DW-1:0]     hwdata_m = '0;
  logic [NM-1:0][DW-1:0]     hrdata_m;
  logic [NM-1:0]             hready_m;
  logic [NM-1:0]             hresp_m;
  logic                      hsel_s;
  logic [31:0]               haddr_s;
  logic [3:0]                hsize_s;
  logic                      hwrite_s;
  logic [DW-1:0]             hwdata_s;
  logic [DW-1:0]             hrdata_s = '0;
  logic                      hready_s = 1'b1;
  logic                      hresp_s = 1'b0;
  logic [NM-1:0]             grant_o;

  ahb_rr_arb #(.NUM_MASTERS(NM), .DWIDTH(DW)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .htrans_m(htrans_m), .haddr_m(haddr_m), .hsize_m(hsize_m), .hwrite_m(hwrite_m),
    .hwdata_m(hwdata_m), .hrdata_m(hrdata_m), .hready_m(hready_m), .hresp_m(hresp_m),
    .hsel_s(hsel_s), .haddr_s(haddr_s), .hsize_s(hsize_s), .hwrite_s(hwrite_s),
    .hwdata_s(hwdata_s), .hrdata_s(hrdata_s), .hready_s(hready_s), .hresp_s(hresp_s),
    .grant_o(grant_o)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic        wr;
  } tr_t;

  tr_t         m_q [NM][$];
  tr_t         exp_q [$];
  tr_t         m_cur [NM];
  tr_t         dp_t;
  logic        dp_v = 1'b0;
  logic [NM-1:0] m_act = '0;
  logic [NM-1:0] took = '0;
  logic [NM-1:0] pend = '0;
  logic [31:0] next_rdata = '0;
  logic        in_rst = 1'b1;
  int          stall_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return 32'hCAFE_0000 | {16'h0, a[19:4]};
  endfunction

  function automatic logic [31:0] wdata_of(input int m);
    return (m == 1) ? 32'h5A5A_5A5A : 32'hD000_0000 + 32'(m);
  endfunction

  task automatic req(input int m, input logic [31:0] a, input logic wr);
    tr_t t;
    t.m = m; t.addr = a; t.wr = wr;
    m_q[m].push_back(t);
  endtask

  task automatic exp_push(input int m, input logic [31:0] a, input logic wr);
    tr_t t;
    t.m = m; t.addr = a; t.wr = wr;
    exp_q.push_back(t);
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge hclk); #1;
      done = (exp_q.size() == 0) && !dp_v && (m_act == '0);
      for (int i = 0; i < NM; i++) if (m_q[i].size() != 0) done = 1'b0;
    end
    if (!done) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Masters and slave: drive just after each rising edge.
  initial begin
    for (int i = 0; i < NM; i++) hwdata_m[i] = wdata_of(i);
    forever begin
      @(posedge hclk); #1;
      hready_s = (stall_cnt > 0) ? 1'b0 : 1'b1;
      if (stall_cnt > 0) stall_cnt--;
      hrdata_s = next_rdata;
      for (int i = 0; i < NM; i++) begin
        if (took[i] || !m_act[i]) begin
          if (m_q[i].size() > 0) begin
            m_cur[i] = m_q[i].pop_front();
            m_act[i] = 1'b1;
          end else begin
            m_act[i] = 1'b0;
          end
        end
        htrans_m[i] = m_act[i] ? ((i == 3) ? 2'b11 : 2'b10) : 2'b00;
        haddr_m[i]  = m_cur[i].addr;
        hwrite_m[i] = m_cur[i].wr;
        hsize_m[i]  = 4'd2;
      end
      took = '0;
    end
  end

  // Monitor and scoreboard on the falling edge.
  initial begin
    logic [NM-1:0] e_rdy;
    logic [DW-1:0] oth_d;
    logic          oth_r;
    int            acc_m;
    forever begin
      @(negedge hclk);
      if (!in_rst) begin
        for (int i = 0; i < NM; i++)
          e_rdy[i] = pend[i] ? 1'b0 : ((dp_v && dp_t.m == i) ? hready_s : 1'b1);
        chk("hready_m", 64'(hready_m), 64'(e_rdy));

        if (dp_v) begin
          oth_d = '0; oth_r = 1'b0;
          for (int i = 0; i < NM; i++)
            if (i != dp_t.m) begin oth_d |= hrdata_m[i]; oth_r |= hresp_m[i]; end
          chk("hrdata_own", 64'(hrdata_m[dp_t.m]), 64'(rdata_of(dp_t.addr)));
          chk("hrdata_oth", 64'(oth_d), 64'd0);
          chk("hresp_own", 64'(hresp_m[dp_t.m]), 64'(hresp_s));
          chk("hresp_oth", 64'(oth_r), 64'd0);
          if (dp_t.wr) chk("hwdata_s", 64'(hwdata_s), 64'(wdata_of(dp_t.m)));
          if (hready_s) dp_v = 1'b0;
        end

        acc_m = -1;
        if (hsel_s) begin
          if (exp_q.size() == 0) begin
            chk("hsel_unexpected", 64'd1, 64'd0);
          end else begin
            chk("grant_o", 64'(grant_o), 64'(1 << exp_q[0].m));
            chk("haddr_s", 64'(haddr_s), 64'(exp_q[0].addr));
            chk("hwrite_s", 64'(hwrite_s), 64'(exp_q[0].wr));
            if (hready_s) begin
              dp_t       = exp_q.pop_front();
              dp_v       = 1'b1;
              next_rdata = rdata_of(dp_t.addr);
              acc_m      = dp_t.m;
              pend[dp_t.m] = 1'b0;
            end
          end
        end else begin
          chk("grant_idle", 64'(grant_o), 64'd0);
          chk("haddr_idle", 64'(haddr_s), 64'd0);
        end

        for (int i = 0; i < NM; i++)
          if (m_act[i] && hready_m[i]) begin
            took[i] = 1'b1;
            if (acc_m != i) pend[i] = 1'b1;
          end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge hclk);
    #3;
    chk("rst_hready_m", 64'(hready_m), 64'hF);
    chk("rst_hsel", 64'(hsel_s), 64'd0);
    chk("rst_grant", 64'(grant_o), 64'd0);
    hresetn = 1'b1;
    in_rst  = 1'b0;

    // Contention from rr_ptr=0: M0..M3 in order.
    req(0, 32'h1000_0000, 1'b0); req(1, 32'h1000_0100, 1'b1);
    req(2, 32'h1000_0200, 1'b0); req(3, 32'h1000_0300, 1'b1);
    exp_push(0, 32'h1000_0000, 1'b0); exp_push(1, 32'h1000_0100, 1'b1);
    exp_push(2, 32'h1000_0200, 1'b0); exp_push(3, 32'h1000_0300, 1'b1);
    wait_idle("contend");

    // Lock: M2 stalled three cycles, M0 (higher ranked at ptr 0) arrives in cycle 2.
    stall_cnt = 3;
    req(2, 32'h2000_0040, 1'b0); exp_push(2, 32'h2000_0040, 1'b0);
    @(posedge hclk); #3;
    req(0, 32'h3000_0000, 1'b1); exp_push(0, 32'h3000_0000, 1'b1);
    wait_idle("lock");

    // Single read from M2, zero added latency.
    req(2, 32'h2000_0010, 1'b0); exp_push(2, 32'h2000_0010, 1'b0);
    @(posedge hclk); #2;
    chk("single_same_cycle_hsel", 64'(hsel_s), 64'd1);
    wait_idle("single");

    // Wrap from rr_ptr=3 with ERROR responses; holds still drain.
    hresp_s = 1'b1;
    req(3, 32'h4000_0030, 1'b0); req(0, 32'h4000_0000, 1'b0);
    exp_push(3, 32'h4000_0030, 1'b0); exp_push(0, 32'h4000_0000, 1'b0);
    wait_idle("wrap");
    hresp_s = 1'b0;

    // Write with two slave wait states in the data phase.
    req(1, 32'h5000_0000, 1'b1); exp_push(1, 32'h5000_0000, 1'b1);
    @(posedge hclk); @(negedge hclk); #1;
    stall_cnt = 2;
    wait_idle("wstall");

    // Reset mid-contention (rr_ptr=2): M2 accepted, three holds pending.
    for (int i = 0; i < NM; i++) req(i, 32'h6000_0000 + 32'(i * 16), 1'b0);
    exp_push(2, 32'h6000_0020, 1'b0); exp_push(3, 32'h6000_0030, 1'b0);
    exp_push(0, 32'h6000_0000, 1'b0); exp_push(1, 32'h6000_0010, 1'b0);
    @(posedge hclk); @(posedge hclk); #3;
    in_rst  = 1'b1;
    hresetn = 1'b0;
    #1;
    chk("arst_hsel", 64'(hsel_s), 64'd0);
    chk("arst_haddr", 64'(haddr_s), 64'd0);
    chk("arst_hsize", 64'(hsize_s), 64'd0);
    chk("arst_hwrite", 64'(hwrite_s), 64'd0);
    chk("arst_hwdata", 64'(hwdata_s), 64'd0);
    chk("arst_hready_m", 64'(hready_m), 64'hF);
    chk("arst_hrdata_m", 64'(|hrdata_m), 64'd0);
    chk("arst_hresp_m", 64'(hresp_m), 64'd0);
    chk("arst_grant", 64'(grant_o), 64'd0);
    for (int i = 0; i < NM; i++) m_q[i].delete();
    exp_q.delete();
    m_act = '0; took = '0; pend = '0; dp_v = 1'b0; stall_cnt = 0;
    repeat (2) @(posedge hclk);
    #3;
    hresetn = 1'b1;
    in_rst  = 1'b0;

    // After reset rr_ptr=0, so M1 beats M3 and nothing from before replays.
    req(3, 32'h7000_0030, 1'b0); req(1, 32'h7000_0010, 1'b1);
    exp_push(1, 32'h7000_0010, 1'b1); exp_push(3, 32'h7000_0030, 1'b0);
    wait_idle("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
